// File: rtl/date_bcd_counter.sv
// BCD day/month/year calendar counter with validated per-field loading.
// Optional leap-year support is enabled by defining LEAP_YEAR_EN.
module date_bcd_counter #(
  parameter int unsigned YEAR_DIGITS = 2,
  parameter logic [7:0]  RESET_DAY   = 8'h01,
  parameter logic [7:0]  RESET_MONTH = 8'h01,
  parameter logic [15:0] RESET_YEAR  = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     ld,
  input  logic [1:0]               fsel,
  input  logic [7:0]               di,
  output logic [7:0]               dd,
  output logic [7:0]               mm,
  output logic [4*YEAR_DIGITS-1:0] yy,
  output logic                     co_m,
  output logic                     co_y,
  output logic                     err
);

  localparam int unsigned YW = 4 * YEAR_DIGITS;
  // Bit offset of the year high byte; collapses onto the low byte when it does not exist.
  localparam int unsigned HI_LSB = (YW > 8) ? 8 : 0;

  logic [7:0]    dd_q, dd_d;
  logic [7:0]    mm_q, mm_d;
  logic [YW-1:0] yy_q, yy_d;
  logic          co_m_q, co_m_d;
  logic          co_y_q, co_y_d;
  logic          err_q, err_d;

  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'h9) r = {v[7:4] + 4'h1, 4'h0};
    else                r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  function automatic logic [YW-1:0] bcd_inc_year(input logic [YW-1:0] v);
    logic [YW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(YEAR_DIGITS); i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'h9) begin
          r[4*i +: 4] = 4'h0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'h1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] dim_of(input logic [7:0] m, input logic leap);
    logic [7:0] r;
    case (m)
      8'h02:                      r = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

`ifdef LEAP_YEAR_EN
  function automatic logic div4(input logic [7:0] b);
    logic r;
    if (b[4]) r = (b[3:0] == 4'h2) || (b[3:0] == 4'h6);
    else      r = (b[3:0] == 4'h0) || (b[3:0] == 4'h4) || (b[3:0] == 4'h8);
    return r;
  endfunction

  // Century years (low byte 00) defer to the high byte: 2000 leap, 1900 not.
  function automatic logic is_leap(input logic [YW-1:0] y);
    logic r;
    if (YEAR_DIGITS == 4 && y[7:0] == 8'h00) r = div4(y[HI_LSB +: 8]);
    else                                     r = div4(y[7:0]);
    return r;
  endfunction
`endif

  logic [7:0]    ld_month;
  logic [YW-1:0] ld_year;
  logic          ld_leap;
  logic          cur_leap;
  logic [7:0]    ld_dim;
  logic [7:0]    cur_dim;
  logic [7:0]    ld_day;
  logic          nib_ok;
  logic          ld_ok;

  // Candidate month/year after the load; unchanged fields keep their current value.
  always_comb begin
    ld_month = (fsel == 2'b01) ? di : mm_q;
    ld_year  = yy_q;
    if (fsel == 2'b10) ld_year[7:0] = di;
    if (fsel == 2'b11 && YEAR_DIGITS == 4) ld_year[HI_LSB +: 8] = di;
  end

`ifdef LEAP_YEAR_EN
  assign ld_leap  = is_leap(ld_year);
  assign cur_leap = is_leap(yy_q);
`else
  assign ld_leap  = 1'b0;
  assign cur_leap = 1'b0;
`endif

  assign ld_dim  = dim_of(ld_month, ld_leap);
  assign cur_dim = dim_of(mm_q, cur_leap);
  assign nib_ok  = (di[7:4] <= 4'h9) && (di[3:0] <= 4'h9);

  always_comb begin
    ld_ok  = 1'b0;
    ld_day = (dd_q > ld_dim) ? ld_dim : dd_q;
    unique case (fsel)
      2'b00: begin
        ld_ok  = nib_ok && (di != 8'h00) && (di <= ld_dim);
        ld_day = di;
      end
      2'b01:   ld_ok = nib_ok && (di != 8'h00) && (di <= 8'h12);
      2'b10:   ld_ok = nib_ok;
      2'b11:   ld_ok = nib_ok && (YEAR_DIGITS == 4);
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    dd_d   = dd_q;
    mm_d   = mm_q;
    yy_d   = yy_q;
    co_m_d = 1'b0;
    co_y_d = 1'b0;
    err_d  = 1'b0;
    if (ld) begin
      if (ld_ok) begin
        dd_d = ld_day;
        mm_d = ld_month;
        yy_d = ld_year;
      end else begin
        err_d = 1'b1;
      end
    end else if (ce) begin
      if (dd_q < cur_dim) begin
        dd_d = bcd_inc8(dd_q);
      end else begin
        dd_d   = 8'h01;
        co_m_d = 1'b1;
        if (mm_q == 8'h12) begin
          mm_d   = 8'h01;
          yy_d   = bcd_inc_year(yy_q);
          co_y_d = 1'b1;
        end else begin
          mm_d = bcd_inc8(mm_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd_q   <= RESET_DAY;
      mm_q   <= RESET_MONTH;
      yy_q   <= RESET_YEAR[YW-1:0];
      co_m_q <= 1'b0;
      co_y_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dd_q   <= dd_d;
      mm_q   <= mm_d;
      yy_q   <= yy_d;
      co_m_q <= co_m_d;
      co_y_q <= co_y_d;
      err_q  <= err_d;
    end
  end

  assign dd   = dd_q;
  assign mm   = mm_q;
  assign yy   = yy_q;
  assign co_m = co_m_q;
  assign co_y = co_y_q;
  assign err  = err_q;

endmodule

// File: tb/tb_date_bcd_counter.sv
// Scoreboard bench for date_bcd_counter (4-digit year); an integer calendar model
// predicts each cycle's outputs, honouring LEAP_YEAR_EN when defined.
module tb_date_bcd_counter;

  localparam int unsigned YD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic        ld = 1'b0;
  logic [1:0]  fsel = 2'b00;
  logic [7:0]  di = 8'h00;
  logic [7:0]  dd;
  logic [7:0]  mm;
  logic [15:0] yy;
  logic        co_m;
  logic        co_y;
  logic        err;

  date_bcd_counter #(
    .YEAR_DIGITS (YD),
    .RESET_DAY   (8'h01),
    .RESET_MONTH (8'h01),
    .RESET_YEAR  (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .ld    (ld),
    .fsel  (fsel),
    .di    (di),
    .dd    (dd),
    .mm    (mm),
    .yy    (yy),
    .co_m  (co_m),
    .co_y  (co_y),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dd;
    logic [7:0]  mm;
    logic [15:0] yy;
    logic        co_m;
    logic        co_y;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_day = 1;
  int   m_mon = 1;
  int   m_year = 0;
  int   co_y_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd2(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic int to_bcd4(input int v);
    return (to_bcd2(v / 100) << 8) | to_bcd2(v % 100);
  endfunction

  function automatic bit m_leap(input int y);
`ifdef LEAP_YEAR_EN
    if (y % 100 != 0) return (y % 4) == 0;
    return ((y / 100) % 4) == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_dim(input int m, input int y);
    if (m == 2) return m_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_step(input bit c, input bit l, input logic [1:0] f,
                            input logic [7:0] d, output exp_t e);
    int  v;
    bit  bad;
    e.co_m = 1'b0;
    e.co_y = 1'b0;
    e.err  = 1'b0;
    if (l) begin
      bad = (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
      v   = int'(d[7:4]) * 10 + int'(d[3:0]);
      if (!bad) begin
        case (f)
          2'b00: if (v >= 1 && v <= m_dim(m_mon, m_year)) m_day = v; else bad = 1'b1;
          2'b01: if (v >= 1 && v <= 12) m_mon = v; else bad = 1'b1;
          2'b10: m_year = (m_year / 100) * 100 + v;
          default: m_year = v * 100 + (m_year % 100);
        endcase
        if (m_day > m_dim(m_mon, m_year)) m_day = m_dim(m_mon, m_year);
      end
      e.err = bad;
    end else if (c) begin
      if (m_day < m_dim(m_mon, m_year)) begin
        m_day++;
      end else begin
        m_day  = 1;
        e.co_m = 1'b1;
        m_mon++;
        if (m_mon > 12) begin
          m_mon  = 1;
          m_year = (m_year + 1) % 10000;
          e.co_y = 1'b1;
        end
      end
    end
    e.dd = 8'(to_bcd2(m_day));
    e.mm = 8'(to_bcd2(m_mon));
    e.yy = 16'(to_bcd4(m_year));
  endtask

  task automatic cycle(input bit c, input bit l, input logic [1:0] f, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    ce   = c;
    ld   = l;
    fsel = f;
    di   = d;
    model_step(c, l, f, d, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("dd", 32'(dd), 32'(e.dd));
      check("mm", 32'(mm), 32'(e.mm));
      check("yy", 32'(yy), 32'(e.yy));
      check("co_m", 32'(co_m), 32'(e.co_m));
      check("co_y", 32'(co_y), 32'(e.co_y));
      check("err", 32'(err), 32'(e.err));
    end
    if (co_y) co_y_seen++;
  endtask

  task automatic set_date(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y);
    cycle(1'b0, 1'b1, 2'b11, y[15:8]);
    cycle(1'b0, 1'b1, 2'b10, y[7:0]);
    cycle(1'b0, 1'b1, 2'b01, m);
    cycle(1'b0, 1'b1, 2'b00, d);
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, {dd, mm, yy, 5'd0, co_m, co_y, err}, {8'h01, 8'h01, 16'h0000, 8'h00});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Month lengths and month carry, with the co_m pulse dropping next cycle.
    set_date(8'h30, 8'h04, 16'h2024);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b0, 2'b00, 8'h00);
    set_date(8'h31, 8'h05, 16'h2024);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);

    // Full-year wrap 9999 -> 0000.
    set_date(8'h31, 8'h12, 16'h9999);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b0, 2'b00, 8'h00);

    // February across leap rules.
    set_date(8'h28, 8'h02, 16'h2024);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    set_date(8'h28, 8'h02, 16'h1900);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    set_date(8'h28, 8'h02, 16'h2000);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    set_date(8'h28, 8'h02, 16'h2023);
    cycle(1'b0, 1'b1, 2'b00, 8'h29);
    set_date(8'h28, 8'h02, 16'h2024);
    cycle(1'b0, 1'b1, 2'b00, 8'h29);

    // Rejected loads and clamping.
    cycle(1'b0, 1'b1, 2'b01, 8'h13);
    cycle(1'b0, 1'b1, 2'b00, 8'h1A);
    cycle(1'b0, 1'b1, 2'b00, 8'h00);
    cycle(1'b0, 1'b1, 2'b10, 8'hA0);
    set_date(8'h31, 8'h01, 16'h2023);
    cycle(1'b0, 1'b1, 2'b01, 8'h02);
    set_date(8'h31, 8'h03, 16'h2023);
    cycle(1'b0, 1'b1, 2'b01, 8'h04);
    set_date(8'h29, 8'h02, 16'h2024);
    cycle(1'b0, 1'b1, 2'b10, 8'h23);

    // Load wins over a simultaneous ce.
    set_date(8'h03, 8'h06, 16'h2024);
    cycle(1'b1, 1'b1, 2'b00, 8'h15);
    check("ld_prio_dd", 32'(dd), 32'h15);

    // A full non-leap year of back-to-back ce pulses.
    set_date(8'h01, 8'h01, 16'h0001);
    co_y_seen = 0;
    for (int i = 0; i < 365; i++) cycle(1'b1, 1'b0, 2'b00, 8'h00);
    check("year_date", {dd, mm, yy}, {8'h01, 8'h01, 16'h0002});
    check("co_y_count", 32'(co_y_seen), 32'd1);

    // Asynchronous reset in the middle of counting.
    set_date(8'h30, 8'h11, 16'h1999);
    cycle(1'b1, 1'b0, 2'b00, 8'h00);
    @(negedge clk);
    ce = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_async");
    @(posedge clk);
    #1 check_reset_state("reset_held");
    @(negedge clk);
    ce     = 1'b0;
    rst_n  = 1'b1;
    m_day  = 1;
    m_mon  = 1;
    m_year = 0;
    cycle(1'b1, 1'b0, 2'b00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
